// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
// Module   : control_unit
// Desc     : Moore FSM sequencing fetch/decode/execute for the 8-bit computer.
//            Define CONTROL_COND_BRANCH_EN to add BEQ (0x23) and BCS (0x26).
// Revision : 1.0
// ============================================================================
module control_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] IR,
    input  logic [3:0] CCR_Result,
    output logic       IR_Load,
    output logic       MAR_Load,
    output logic       PC_Load,
    output logic       PC_Inc,
    output logic       A_Load,
    output logic       B_Load,
    output logic [2:0] ALU_Sel,
    output logic       CCR_Load,
    output logic [1:0] Bus1_Sel,
    output logic [1:0] Bus2_Sel,
    output logic       write
);

    localparam logic [4:0] S_FETCH_0    = 5'd0;
    localparam logic [4:0] S_FETCH_1    = 5'd1;
    localparam logic [4:0] S_FETCH_2    = 5'd2;
    localparam logic [4:0] S_DECODE_3   = 5'd3;
    localparam logic [4:0] S_OPND_4     = 5'd4;
    localparam logic [4:0] S_OPND_INC_5 = 5'd5;
    localparam logic [4:0] S_BR_WAIT_5  = 5'd6;
    localparam logic [4:0] S_BR_LOAD_6  = 5'd7;
    localparam logic [4:0] S_LDA_MEM    = 5'd8;
    localparam logic [4:0] S_LDB_MEM    = 5'd9;
    localparam logic [4:0] S_DIR_ADDR_6 = 5'd10;
    localparam logic [4:0] S_DIR_WAIT_7 = 5'd11;
    localparam logic [4:0] S_STA_7      = 5'd12;
    localparam logic [4:0] S_STB_7      = 5'd13;
    localparam logic [4:0] S_ADD_4      = 5'd14;
    localparam logic [4:0] S_SUB_4      = 5'd15;
`ifdef CONTROL_COND_BRANCH_EN
    localparam logic [4:0] S_SKIP_4     = 5'd16;
`endif

    localparam logic [7:0] OP_LDA_IMM = 8'h86;
    localparam logic [7:0] OP_LDA_DIR = 8'h87;
    localparam logic [7:0] OP_LDB_IMM = 8'h88;
    localparam logic [7:0] OP_LDB_DIR = 8'h89;
    localparam logic [7:0] OP_STA_DIR = 8'h96;
    localparam logic [7:0] OP_STB_DIR = 8'h97;
    localparam logic [7:0] OP_ADD_AB  = 8'h42;
    localparam logic [7:0] OP_SUB_AB  = 8'h43;
    localparam logic [7:0] OP_BRA     = 8'h20;
`ifdef CONTROL_COND_BRANCH_EN
    localparam logic [7:0] OP_BEQ     = 8'h23;
    localparam logic [7:0] OP_BCS     = 8'h26;
`endif

    localparam logic [1:0] BUS1_PC   = 2'b00;
    localparam logic [1:0] BUS1_A    = 2'b01;
    localparam logic [1:0] BUS1_B    = 2'b10;
    localparam logic [1:0] BUS2_ALU  = 2'b00;
    localparam logic [1:0] BUS2_BUS1 = 2'b01;
    localparam logic [1:0] BUS2_MEM  = 2'b10;
    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;

    logic [4:0] r_state;
    logic [4:0] w_next_state;
    logic       w_is_branch;
    logic       w_unused_ccr;

    assign w_unused_ccr = ^CCR_Result;

`ifdef CONTROL_COND_BRANCH_EN
    assign w_is_branch = (IR == OP_BRA) || (IR == OP_BEQ) || (IR == OP_BCS);
`else
    assign w_is_branch = (IR == OP_BRA);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH_0;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Exec paths share operand states; IR is held until the next fetch so it
    // steers the later branches of the sequence.
    always_comb begin
        w_next_state = S_FETCH_0;
        case (r_state)
            S_FETCH_0:  w_next_state = S_FETCH_1;
            S_FETCH_1:  w_next_state = S_FETCH_2;
            S_FETCH_2:  w_next_state = S_DECODE_3;
            S_DECODE_3: begin
                case (IR)
                    OP_LDA_IMM, OP_LDB_IMM, OP_LDA_DIR, OP_LDB_DIR,
                    OP_STA_DIR, OP_STB_DIR, OP_BRA: w_next_state = S_OPND_4;
                    OP_ADD_AB:  w_next_state = S_ADD_4;
                    OP_SUB_AB:  w_next_state = S_SUB_4;
`ifdef CONTROL_COND_BRANCH_EN
                    // CCR only loads in ADD/SUB exec, so decode sees the exec-4 flags.
                    OP_BEQ:     w_next_state = CCR_Result[2] ? S_OPND_4 : S_SKIP_4;
                    OP_BCS:     w_next_state = CCR_Result[0] ? S_OPND_4 : S_SKIP_4;
`endif
                    default:    w_next_state = S_FETCH_0;
                endcase
            end
            S_OPND_4:     w_next_state = w_is_branch ? S_BR_WAIT_5 : S_OPND_INC_5;
            S_BR_WAIT_5:  w_next_state = S_BR_LOAD_6;
            S_OPND_INC_5: begin
                case (IR)
                    OP_LDA_IMM: w_next_state = S_LDA_MEM;
                    OP_LDB_IMM: w_next_state = S_LDB_MEM;
                    default:    w_next_state = S_DIR_ADDR_6;
                endcase
            end
            S_DIR_ADDR_6: begin
                case (IR)
                    OP_STA_DIR: w_next_state = S_STA_7;
                    OP_STB_DIR: w_next_state = S_STB_7;
                    default:    w_next_state = S_DIR_WAIT_7;
                endcase
            end
            S_DIR_WAIT_7: w_next_state = (IR == OP_LDA_DIR) ? S_LDA_MEM : S_LDB_MEM;
            default:      w_next_state = S_FETCH_0;
        endcase
    end

    always_comb begin
        IR_Load  = 1'b0;
        MAR_Load = 1'b0;
        PC_Load  = 1'b0;
        PC_Inc   = 1'b0;
        A_Load   = 1'b0;
        B_Load   = 1'b0;
        ALU_Sel  = ALU_ADD;
        CCR_Load = 1'b0;
        Bus1_Sel = BUS1_PC;
        Bus2_Sel = BUS2_ALU;
        write    = 1'b0;
        if (reset) begin
            case (r_state)
                S_FETCH_0, S_OPND_4: begin
                    Bus1_Sel = BUS1_PC;
                    Bus2_Sel = BUS2_BUS1;
                    MAR_Load = 1'b1;
                end
`ifdef CONTROL_COND_BRANCH_EN
                S_SKIP_4,
`endif
                S_FETCH_1, S_OPND_INC_5: PC_Inc = 1'b1;
                S_FETCH_2: begin
                    Bus2_Sel = BUS2_MEM;
                    IR_Load  = 1'b1;
                end
                S_BR_LOAD_6: begin
                    Bus2_Sel = BUS2_MEM;
                    PC_Load  = 1'b1;
                end
                S_LDA_MEM: begin
                    Bus2_Sel = BUS2_MEM;
                    A_Load   = 1'b1;
                end
                S_LDB_MEM: begin
                    Bus2_Sel = BUS2_MEM;
                    B_Load   = 1'b1;
                end
                S_DIR_ADDR_6: begin
                    Bus2_Sel = BUS2_MEM;
                    MAR_Load = 1'b1;
                end
                S_STA_7: begin
                    Bus1_Sel = BUS1_A;
                    write    = 1'b1;
                end
                S_STB_7: begin
                    Bus1_Sel = BUS1_B;
                    write    = 1'b1;
                end
                S_ADD_4, S_SUB_4: begin
                    Bus1_Sel = BUS1_B;
                    Bus2_Sel = BUS2_ALU;
                    ALU_Sel  = (r_state == S_SUB_4) ? ALU_SUB : ALU_ADD;
                    A_Load   = 1'b1;
                    CCR_Load = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_control_unit
// Desc     : Random-opcode bench; per-cycle expected control words are queued
//            from the instruction tables and checked by a separate monitor.
// Revision : 1.0
// ============================================================================
module tb_control_unit;

    typedef logic [14:0] vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] IR;
    logic [3:0] CCR_Result;
    logic       IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load, write;
    logic [2:0] ALU_Sel;
    logic [1:0] Bus1_Sel, Bus2_Sel;

    control_unit dut (
        .clk(clk), .reset(reset), .IR(IR), .CCR_Result(CCR_Result),
        .IR_Load(IR_Load), .MAR_Load(MAR_Load), .PC_Load(PC_Load), .PC_Inc(PC_Inc),
        .A_Load(A_Load), .B_Load(B_Load), .ALU_Sel(ALU_Sel), .CCR_Load(CCR_Load),
        .Bus1_Sel(Bus1_Sel), .Bus2_Sel(Bus2_Sel), .write(write)
    );

    always #5 clk = ~clk;

    vec_t exp_q[$];
    vec_t seq[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cycle    = 0;
    int   exp_writes  = 0;
    int   seen_writes = 0;

    // Control word: {IR_Load,MAR_Load,PC_Load,PC_Inc,A_Load,B_Load,ALU_Sel,CCR_Load,Bus1,Bus2,write}
    function automatic vec_t uop(input logic irl, input logic marl, input logic pcl,
                                 input logic pci, input logic al, input logic bl,
                                 input logic [2:0] alu, input logic ccrl,
                                 input logic [1:0] b1, input logic [1:0] b2, input logic wr);
        return {irl, marl, pcl, pci, al, bl, alu, ccrl, b1, b2, wr};
    endfunction

    function automatic vec_t mar_from_pc();
        return uop(0, 1, 0, 0, 0, 0, 3'b000, 0, 2'b00, 2'b01, 0);
    endfunction
    function automatic vec_t pc_inc();
        return uop(0, 0, 0, 1, 0, 0, 3'b000, 0, 2'b00, 2'b00, 0);
    endfunction
    function automatic vec_t mem_to(input logic marl, input logic pcl, input logic al, input logic bl);
        return uop(0, marl, pcl, 0, al, bl, 3'b000, 0, 2'b00, 2'b10, 0);
    endfunction

    // Reference: expected control word for every cycle of one instruction.
    task automatic build(input logic [7:0] op, input logic [3:0] ccr);
        logic taken;
        seq = {};
        seq.push_back(mar_from_pc());
        seq.push_back(pc_inc());
        seq.push_back(uop(1, 0, 0, 0, 0, 0, 3'b000, 0, 2'b00, 2'b10, 0));
        seq.push_back('0);
        case (op)
            8'h86, 8'h88: begin
                seq.push_back(mar_from_pc());
                seq.push_back(pc_inc());
                seq.push_back(mem_to(0, 0, op == 8'h86, op == 8'h88));
            end
            8'h87, 8'h89: begin
                seq.push_back(mar_from_pc());
                seq.push_back(pc_inc());
                seq.push_back(mem_to(1, 0, 0, 0));
                seq.push_back('0);
                seq.push_back(mem_to(0, 0, op == 8'h87, op == 8'h89));
            end
            8'h96, 8'h97: begin
                seq.push_back(mar_from_pc());
                seq.push_back(pc_inc());
                seq.push_back(mem_to(1, 0, 0, 0));
                seq.push_back(uop(0, 0, 0, 0, 0, 0, 3'b000, 0,
                                  (op == 8'h96) ? 2'b01 : 2'b10, 2'b00, 1));
                exp_writes++;
            end
            8'h42, 8'h43: begin
                seq.push_back(uop(0, 0, 0, 0, 1, 0, (op == 8'h43) ? 3'b001 : 3'b000,
                                  1, 2'b10, 2'b00, 0));
            end
            8'h20: begin
                seq.push_back(mar_from_pc());
                seq.push_back('0);
                seq.push_back(mem_to(0, 1, 0, 0));
            end
`ifdef CONTROL_COND_BRANCH_EN
            8'h23, 8'h26: begin
                taken = (op == 8'h23) ? ccr[2] : ccr[0];
                if (taken) begin
                    seq.push_back(mar_from_pc());
                    seq.push_back('0);
                    seq.push_back(mem_to(0, 1, 0, 0));
                end else begin
                    seq.push_back(pc_inc());
                end
            end
`endif
            default: taken = 1'b0;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [7:0] op, input logic [3:0] ccr);
        build(op, ccr);
        IR = op;
        CCR_Result = ccr;
        foreach (seq[i]) exp_q.push_back(seq[i]);
        repeat (seq.size()) tick();
    endtask

    // Monitor: independent of stimulus, one pop per cycle while expectations exist.
    always @(negedge clk) begin
        vec_t act;
        vec_t e;
        cycle++;
        act = {IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, ALU_Sel,
               CCR_Load, Bus1_Sel, Bus2_Sel, write};
        if (write === 1'b1) seen_writes++;
        n_checks++;
        if (PC_Inc === 1'b1 && PC_Load === 1'b1) begin
            n_fail++;
            $display("FAIL pc_inc_and_load cycle %0d: got both 1, required not both", cycle);
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (act !== e) begin
                n_fail++;
                $display("FAIL ctrl_word cycle %0d IR=%h: got %b required %b", cycle, IR, act, e);
            end
        end
    end

    logic [7:0] ops[11] = '{8'h86, 8'h88, 8'h87, 8'h89, 8'h96, 8'h97,
                            8'h42, 8'h43, 8'h20, 8'h23, 8'h26};

    initial begin
        logic [7:0] op;
        reset = 1'b0;
        IR = 8'h00;
        CCR_Result = 4'h0;
        tick();
        exp_q.push_back('0);
        exp_q.push_back('0);
        tick();
        tick();
        reset = 1'b1;

        issue(8'h86, 4'h0);
        issue(8'h96, 4'h0);
        issue(8'h43, 4'h0);
        issue(8'h20, 4'h0);
        issue(8'h23, 4'b0100);
        issue(8'h23, 4'b0000);
        issue(8'h26, 4'b0001);
        issue(8'h26, 4'b1110);
        issue(8'hFF, 4'h0);

        // Reset pulse in the middle of LDA_DIR (state after operand increment).
        build(8'h87, 4'h0);
        IR = 8'h87;
        for (int i = 0; i < 6; i++) exp_q.push_back(seq[i]);
        repeat (6) tick();
        reset = 1'b0;
        exp_q.push_back('0);
        exp_q.push_back('0);
        tick();
        tick();
        reset = 1'b1;
        issue(8'h89, 4'h0);

        for (int n = 0; n < 120; n++) begin
            if ($urandom_range(0, 3) == 0) op = 8'($urandom);
            else op = ops[$urandom_range(0, 10)];
            issue(op, 4'($urandom));
        end

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected words left, required 0", exp_q.size());
        end
        n_checks++;
        if (seen_writes != exp_writes) begin
            n_fail++;
            $display("FAIL write_count: got %0d pulses, required %0d", seen_writes, exp_writes);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
